// File: rtl/huffman_pkg.sv
// Shared defaults, FSM state encoding and width helper for the canonical-Huffman decoder.
package huffman_pkg;

   localparam int SYM_W_DEF   = 8;
   localparam int MAX_LEN_DEF = 8;

   typedef enum logic [2:0] {
      IDLE,
      BUILD,
      DECODE,
      EMIT,
      ERROR
   } state_t;

   // Width of an index that can address lengths 0..max_len.
   function automatic int len_addr_w(input int max_len);
      return $clog2(max_len + 1);
   endfunction

endpackage

// File: rtl/huffman_canon_table.sv
// Per-length count table plus the first-code / rank-offset tables derived from it,
// filled one length per cycle while build_en is high.
module huffman_canon_table
   import huffman_pkg::*;
#(
   parameter int SYM_W   = SYM_W_DEF,
   parameter int MAX_LEN = MAX_LEN_DEF
) (
   input  logic                            clk,
   input  logic                            n_rst,
   input  logic                            cnt_we,
   input  logic [len_addr_w(MAX_LEN)-1:0]  cnt_addr,
   input  logic [SYM_W:0]                  cnt_data,
   input  logic                            build_clr,
   input  logic                            build_en,
   input  logic [len_addr_w(MAX_LEN)-1:0]  len,
   output logic [SYM_W:0]                  count,
   output logic [SYM_W:0]                  first,
   output logic [SYM_W:0]                  offs,
   output logic                            done
);

   localparam int AW = len_addr_w(MAX_LEN);
   localparam int W  = SYM_W + 1;

   logic [W-1:0] count_mem [0:MAX_LEN];
   logic [W-1:0] first_mem [0:MAX_LEN];
   logic [W-1:0] offs_mem  [0:MAX_LEN];

   logic [AW-1:0] idx_reg;
   logic [W-1:0]  c_reg;
   logic [W-1:0]  o_reg;

   // Table storage carries no reset; the write gate lives in the top level.
   always_ff @(posedge clk) begin
      if (cnt_we && (cnt_addr != '0) && (cnt_addr <= AW'(MAX_LEN)))
         count_mem[cnt_addr] <= cnt_data;
      if (build_en) begin
         first_mem[idx_reg] <= c_reg;
         offs_mem[idx_reg]  <= o_reg;
      end
   end

   always_ff @(posedge clk) begin
      if (!n_rst || build_clr) begin
         idx_reg <= AW'(1);
         c_reg   <= '0;
         o_reg   <= '0;
      end else if (build_en) begin
         idx_reg <= idx_reg + AW'(1);
         c_reg   <= (c_reg + count_mem[idx_reg]) << 1;
         o_reg   <= o_reg + count_mem[idx_reg];
      end
   end

   assign done  = build_en && (idx_reg == AW'(MAX_LEN));
   assign count = count_mem[len];
   assign first = first_mem[len];
   assign offs  = offs_mem[len];

endmodule

// File: rtl/huffman_canon_decoder.sv
// Serial canonical-Huffman decoder: one code bit per cycle in, one symbol per
// codeword out over valid/ready, with a sticky error on an unmatched code.
module huffman_canon_decoder
   import huffman_pkg::*;
#(
   parameter int SYM_W   = SYM_W_DEF,
   parameter int MAX_LEN = MAX_LEN_DEF
) (
   input  logic                            clk,
   input  logic                            n_rst,
   input  logic                            cnt_we,
   input  logic [len_addr_w(MAX_LEN)-1:0]  cnt_addr,
   input  logic [SYM_W:0]                  cnt_data,
   input  logic                            sym_we,
   input  logic [SYM_W-1:0]                sym_addr,
   input  logic [SYM_W-1:0]                sym_data,
   input  logic                            start,
   input  logic                            flush,
   input  logic                            bit_in,
   input  logic                            bit_valid,
   output logic                            bit_ready,
   output logic [SYM_W-1:0]                sym_out,
   output logic                            sym_valid,
   input  logic                            sym_ready,
   output logic                            busy,
   output logic                            err_flag
);

   localparam int AW = len_addr_w(MAX_LEN);
   localparam int W  = SYM_W + 1;

   state_t state_reg, state_next;

   logic [MAX_LEN-1:0] code_reg;
   logic [AW-1:0]      len_reg;
   logic [SYM_W-1:0]   symtab [0:2**SYM_W-1];

   logic [MAX_LEN-1:0] code_next;
   logic [AW-1:0]      len_next;
   logic [W-1:0]       tab_count, tab_first, tab_offs, diff;
   logic [SYM_W-1:0]   rd_addr;
   logic               build_done, take, hit, overrun, start_ok, cfg_ok;

   assign cfg_ok    = (state_reg == IDLE);
   assign start_ok  = start && !flush && (state_reg == IDLE || state_reg == ERROR);
   assign bit_ready = (state_reg == DECODE);
   assign busy      = (state_reg != IDLE);
   assign take      = bit_valid && bit_ready;

   assign code_next = {code_reg[MAX_LEN-2:0], bit_in};
   assign len_next  = len_reg + AW'(1);

   huffman_canon_table #(
      .SYM_W   (SYM_W),
      .MAX_LEN (MAX_LEN)
   ) u_table (
      .clk       (clk),
      .n_rst     (n_rst),
      .cnt_we    (cnt_we && cfg_ok),
      .cnt_addr  (cnt_addr),
      .cnt_data  (cnt_data),
      .build_clr (start_ok),
      .build_en  (state_reg == BUILD),
      .len       (len_next),
      .count     (tab_count),
      .first     (tab_first),
      .offs      (tab_offs),
      .done      (build_done)
   );

   // Unsigned wrap makes codes below first[len] look huge, so one compare suffices.
   assign diff    = W'(code_next) - tab_first;
   assign hit     = take && (diff < tab_count);
   assign overrun = take && !hit && (len_next == AW'(MAX_LEN));
   assign rd_addr = SYM_W'(tab_offs + diff);

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:    if (start)      state_next = BUILD;
         BUILD:   if (build_done) state_next = DECODE;
         DECODE: begin
            if (hit)          state_next = EMIT;
            else if (overrun) state_next = ERROR;
         end
         EMIT:    if (sym_ready)  state_next = DECODE;
         ERROR:   if (start)      state_next = BUILD;
         default:                 state_next = IDLE;
      endcase
      if (flush)
         state_next = IDLE;
   end

   always_ff @(posedge clk) begin
      if (sym_we && cfg_ok)
         symtab[sym_addr] <= sym_data;
   end

   always_ff @(posedge clk) begin
      if (!n_rst) begin
         state_reg <= IDLE;
         code_reg  <= '0;
         len_reg   <= '0;
         sym_valid <= 1'b0;
         sym_out   <= '0;
         err_flag  <= 1'b0;
      end else begin
         state_reg <= state_next;
         if (flush) begin
            code_reg  <= '0;
            len_reg   <= '0;
            sym_valid <= 1'b0;
         end else begin
            if (start_ok) begin
               err_flag <= 1'b0;
               code_reg <= '0;
               len_reg  <= '0;
            end
            if (take) begin
               if (hit) begin
                  sym_out   <= symtab[rd_addr];
                  sym_valid <= 1'b1;
                  code_reg  <= '0;
                  len_reg   <= '0;
               end else if (overrun) begin
                  err_flag <= 1'b1;
                  code_reg <= '0;
                  len_reg  <= '0;
               end else begin
                  code_reg <= code_next;
                  len_reg  <= len_next;
               end
            end
            if (state_reg == EMIT && sym_ready)
               sym_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_huffman_canon_decoder.sv
// Directed bench for huffman_canon_decoder: table-driven stream decode plus
// hand-written backpressure, error, recovery, flush and reset sequences.
module tb_huffman_canon_decoder;

   logic       clk = 1'b0;
   logic       n_rst;
   logic       cnt_we;
   logic [3:0] cnt_addr;
   logic [8:0] cnt_data;
   logic       sym_we;
   logic [7:0] sym_addr;
   logic [7:0] sym_data;
   logic       start;
   logic       flush;
   logic       bit_in;
   logic       bit_valid;
   logic       bit_ready;
   logic [7:0] sym_out;
   logic       sym_valid;
   logic       sym_ready;
   logic       busy;
   logic       err_flag;

   int checks_total = 0;
   int checks_pass  = 0;

   always #5 clk = ~clk;

   huffman_canon_decoder dut (
      .clk       (clk),
      .n_rst     (n_rst),
      .cnt_we    (cnt_we),
      .cnt_addr  (cnt_addr),
      .cnt_data  (cnt_data),
      .sym_we    (sym_we),
      .sym_addr  (sym_addr),
      .sym_data  (sym_data),
      .start     (start),
      .flush     (flush),
      .bit_in    (bit_in),
      .bit_valid (bit_valid),
      .bit_ready (bit_ready),
      .sym_out   (sym_out),
      .sym_valid (sym_valid),
      .sym_ready (sym_ready),
      .busy      (busy),
      .err_flag  (err_flag)
   );

   typedef struct {
      logic       b;
      logic       exp_v;
      logic [7:0] exp_s;
   } vec_t;

   vec_t vecs [9];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks_total++;
      if (act !== exp)
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      else
         checks_pass++;
   endtask

   task automatic cfg_count(input int a, input int d);
      cnt_we   = 1'b1;
      cnt_addr = 4'(a);
      cnt_data = 9'(d);
      tick();
      cnt_we   = 1'b0;
   endtask

   task automatic cfg_sym(input int a, input int d);
      sym_we   = 1'b1;
      sym_addr = 8'(a);
      sym_data = 8'(d);
      tick();
      sym_we   = 1'b0;
   endtask

   // Pulses start and returns the number of cycles until the decoder accepts bits.
   task automatic start_build(output int n);
      start = 1'b1;
      tick();
      start = 1'b0;
      check("err_clear_on_start", err_flag, 0);
      n = 0;
      while (!bit_ready && n < 100) begin
         tick();
         n++;
      end
   endtask

   task automatic send_bit(input logic b);
      int guard = 0;
      bit_valid = 1'b1;
      bit_in    = b;
      while (!bit_ready && guard < 50) begin
         tick();
         guard++;
      end
      if (guard >= 50)
         check("bit_ready_timeout", 0, 1);
      tick();
      bit_valid = 1'b0;
   endtask

   task automatic run_vectors(input int from);
      for (int i = from; i < 9; i++) begin
         send_bit(vecs[i].b);
         $display("vec %0d: bit=%0d sym_valid=%0d sym_out=0x%02h", i, vecs[i].b, sym_valid, sym_out);
         check($sformatf("vec%0d_valid", i), sym_valid, vecs[i].exp_v);
         if (vecs[i].exp_v)
            check($sformatf("vec%0d_sym", i), sym_out, vecs[i].exp_s);
      end
   endtask

   initial begin
      int n;
      // Codes: 0 -> 41, 10 -> 42, 110 -> 43, 111 -> 44
      vecs[0] = '{1'b0, 1'b1, 8'h41};
      vecs[1] = '{1'b1, 1'b0, 8'h00};
      vecs[2] = '{1'b0, 1'b1, 8'h42};
      vecs[3] = '{1'b1, 1'b0, 8'h00};
      vecs[4] = '{1'b1, 1'b0, 8'h00};
      vecs[5] = '{1'b0, 1'b1, 8'h43};
      vecs[6] = '{1'b1, 1'b0, 8'h00};
      vecs[7] = '{1'b1, 1'b0, 8'h00};
      vecs[8] = '{1'b1, 1'b1, 8'h44};

      n_rst = 1'b0; cnt_we = 1'b0; cnt_addr = '0; cnt_data = '0;
      sym_we = 1'b0; sym_addr = '0; sym_data = '0;
      start = 1'b0; flush = 1'b0; bit_in = 1'b1; bit_valid = 1'b1; sym_ready = 1'b1;

      // Reset with bit_valid asserted
      tick(); tick(); tick();
      $display("reset: busy=%0d bit_ready=%0d sym_valid=%0d err=%0d", busy, bit_ready, sym_valid, err_flag);
      check("rst_busy", busy, 0);
      check("rst_bit_ready", bit_ready, 0);
      check("rst_sym_valid", sym_valid, 0);
      check("rst_err", err_flag, 0);
      check("rst_sym_out", sym_out, 0);
      bit_valid = 1'b0;
      n_rst = 1'b1;
      tick();

      // Basic decode
      cfg_count(1, 1); cfg_count(2, 1); cfg_count(3, 2);
      for (int l = 4; l <= 8; l++) cfg_count(l, 0);
      cfg_sym(0, 8'h41); cfg_sym(1, 8'h42); cfg_sym(2, 8'h43); cfg_sym(3, 8'h44);
      start_build(n);
      $display("build1: %0d cycles", n);
      check("build1_cycles", n, 8);
      run_vectors(0);

      // Backpressure on the first symbol
      tick();
      sym_ready = 1'b0;
      send_bit(1'b0);
      check("bp_first_valid", sym_valid, 1);
      check("bp_first_sym", sym_out, 8'h41);
      bit_valid = 1'b1;
      bit_in    = 1'b1;
      for (int k = 0; k < 5; k++) begin
         tick();
         $display("bp hold %0d: sym_valid=%0d sym_out=0x%02h bit_ready=%0d", k, sym_valid, sym_out, bit_ready);
         check($sformatf("bp_hold%0d_sym", k), sym_out, 8'h41);
         check($sformatf("bp_hold%0d_valid", k), sym_valid, 1);
         check($sformatf("bp_hold%0d_ready", k), bit_ready, 0);
      end
      bit_valid = 1'b0;
      sym_ready = 1'b1;
      tick();
      check("bp_release_valid", sym_valid, 0);
      run_vectors(1);

      // Invalid code: only count[1]=1
      flush = 1'b1; tick(); flush = 1'b0;
      check("flush_to_idle", busy, 0);
      cfg_count(2, 0); cfg_count(3, 0);
      start_build(n);
      check("build2_cycles", n, 8);
      for (int k = 0; k < 8; k++) begin
         send_bit(1'b1);
         $display("err bit %0d: err=%0d sym_valid=%0d bit_ready=%0d", k, err_flag, sym_valid, bit_ready);
         check($sformatf("err_bit%0d_flag", k), err_flag, (k == 7) ? 1 : 0);
         check($sformatf("err_bit%0d_valid", k), sym_valid, 0);
      end
      check("err_bit_ready", bit_ready, 0);
      check("err_busy", busy, 1);
      tick(); tick();
      check("err_held", err_flag, 1);
      check("err_stuck_ready", bit_ready, 0);

      // Recovery via start from ERROR
      start_build(n);
      $display("recover build: %0d cycles err=%0d", n, err_flag);
      check("recover_cycles", n, 8);
      check("recover_err", err_flag, 0);
      send_bit(1'b0);
      check("recover_valid", sym_valid, 1);
      check("recover_sym", sym_out, 8'h41);

      // Flush mid-codeword
      send_bit(1'b1);
      send_bit(1'b1);
      flush = 1'b1; tick(); flush = 1'b0;
      $display("mid flush: busy=%0d bit_ready=%0d", busy, bit_ready);
      check("midflush_busy", busy, 0);
      check("midflush_ready", bit_ready, 0);
      start_build(n);
      check("midflush_build", n, 8);
      send_bit(1'b0);
      check("midflush_valid", sym_valid, 1);
      check("midflush_sym", sym_out, 8'h41);

      // Symbol table writes outside IDLE are dropped
      tick();
      cfg_sym(0, 8'h99);
      send_bit(1'b0);
      check("cfg_ignored_sym", sym_out, 8'h41);

      // Reset mid-codeword
      tick();
      send_bit(1'b1);
      n_rst = 1'b0; tick(); n_rst = 1'b1;
      check("midrst_busy", busy, 0);
      check("midrst_valid", sym_valid, 0);
      check("midrst_sym_out", sym_out, 0);

      $display("%0d/%0d checks passed", checks_pass, checks_total);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
